instr_issue_queue: RTL and testbench

Host-side instruction buffer and issuer that sits directly upstream of the matrix coprocessor's control unit. Accepts 32-bit instructions from the host bridge into a FIFO and releases them one at a time as a single-cycle `activate_instruction` pulse. After each release it waits for the coprocessor's completion pulse before issuing the next. Captures the 16-bit read-back data of READ instructions for the host and flags illegal opcodes and hung operations.

---
 rtl/instr_issue_queue_pkg.sv | 31 +++
 rtl/instr_issue_queue_if.sv | 30 +++
 rtl/instr_issue_queue_fifo.sv | 55 +++++
 rtl/instr_issue_queue.sv | 136 +++++++++++++
 tb/tb_instr_issue_queue.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_issue_queue_pkg.sv
// Shared definitions for the coprocessor instruction path: opcodes,
// the legal-opcode test and the issuer FSM state encoding.
package cop_pkg;

    typedef enum logic [3:0] {
        OP_READ  = 4'd1,
        OP_WRITE = 4'd2,
        OP_SUM   = 4'd3,
        OP_DIFF  = 4'd4,
        OP_PROD  = 4'd5,
        OP_SCALE = 4'd6,
        OP_TRANS = 4'd7,
        OP_TRACE = 4'd8,
        OP_DET2  = 4'd9,
        OP_DET3  = 4'd10,
        OP_DET4  = 4'd11,
        OP_DET5  = 4'd12
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Opcodes 0 and 13..15 have no meaning to the coprocessor.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op >= OP_READ) && (op <= OP_DET5);
    endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// Bus bundle between the host bridge, the issue queue and the coprocessor.
// Handshake: a host word transfers on a rising edge where host_valid and
// host_ready are both high; host_ready depends only on registered state,
// and the host keeps host_instr/host_valid stable until it sees ready.
// activate_instruction and cop_done are single-cycle pulses with no
// back-pressure; cop_data is meaningful only while cop_done is high.
interface instr_issue_queue_if;
    logic [31:0] host_instr;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] instruction;
    logic        activate_instruction;
    logic        cop_done;
    logic [15:0] cop_data;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ack;

    // Environment side: host bridge plus coprocessor.
    modport master (
        output host_instr, host_valid, cop_done, cop_data, result_ack,
        input  host_ready, instruction, activate_instruction, result, result_valid
    );

    // Issue queue side.
    modport slave (
        input  host_instr, host_valid, cop_done, cop_data, result_ack,
        output host_ready, instruction, activate_instruction, result, result_valid
    );
endinterface

// File: rtl/instr_issue_queue_fifo.sv
// Synchronous FIFO with a combinational head (no read latency).
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_issue_queue.sv
// Buffers host instructions and issues them one at a time to the matrix
// coprocessor, waiting for each completion before the next issue.
module instr_issue_queue
    import cop_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_issue_queue_if.slave      bus,
    input  logic                    err_clr,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_opcode,
    output logic                    err_timeout,
    output state_t                  fsm_state
);
    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_next;
    logic [31:0]     head;
    logic            full;
    logic            empty;
    logic            pop;
    logic            load;
    logic            opc_bad;
    logic            done_hit;
    logic            timeout_hit;
    logic [3:0]      opc_r;
    logic [TW-1:0]   timer;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.host_valid),
        .pop   (pop),
        .din   (bus.host_instr),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Ready comes from registered occupancy only, so a same-cycle pop
    // never opens a slot for the host.
    assign bus.host_ready = !full;
    assign busy           = (state != ST_IDLE) || !empty;
    assign fsm_state      = state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and pop decision; illegal heads are dropped in IDLE.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load        = 1'b0;
        opc_bad     = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_legal_op(head[3:0])) begin
                        load       = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        opc_bad = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.cop_done) begin
                    done_hit   = 1'b1;
                    state_next = ST_IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Issue registers: the pulse is registered out of ISSUE, so it is
    // high during the first WAIT cycle and the timer starts from zero then.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.instruction          <= '0;
            bus.activate_instruction <= 1'b0;
            opc_r                    <= '0;
            timer                    <= '0;
        end else begin
            bus.activate_instruction <= (state == ST_ISSUE);
            if (load) begin
                bus.instruction <= head;
                opc_r           <= head[3:0];
            end
            if (state == ST_ISSUE)     timer <= '0;
            else if (state == ST_WAIT) timer <= timer + TW'(1);
        end
    end

    // READ data capture; a completion beats a coincident acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
        end else if (done_hit && (opc_r == OP_READ)) begin
            bus.result       <= bus.cop_data;
            bus.result_valid <= 1'b1;
        end else if (bus.result_ack) begin
            bus.result_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (opc_bad)      err_opcode <= 1'b1;
            else if (err_clr) err_opcode <= 1'b0;
            if (timeout_hit)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue with a queue-and-timestamp model
// checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_instr_issue_queue;
    import cop_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [3:0] count;
    logic       err_opcode;
    logic       err_timeout;
    state_t     fsm_state;

    instr_issue_queue_if bus ();

    instr_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .err_clr     (err_clr),
        .busy        (busy),
        .count       (count),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of accepted words; an outstanding instruction is tracked by
    // the number of edges since it left the queue (0 = just popped,
    // 1 = issue edge, completion accepted from then on).
    logic [31:0] m_q[$];
    bit          m_iss = 0;
    int          m_age = 0;
    logic [31:0] m_cur = '0;
    bit          m_act = 0;
    logic [15:0] m_res = '0;
    bit          m_rv = 0;
    bit          m_eo = 0;
    bit          m_et = 0;
    bit          mv_can_push, mv_can_pop, mv_done, mv_tmo, mv_bad;
    logic [31:0] mv_head;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_iss = 0; m_age = 0; m_cur = '0; m_act = 0;
            m_res = '0; m_rv = 0; m_eo = 0; m_et = 0;
        end else begin
            mv_can_push = (m_q.size() < DEPTH);
            mv_can_pop  = !m_iss && (m_q.size() != 0);
            mv_done     = m_iss && (m_age >= 1) && (bus.cop_done === 1'b1);
            mv_tmo      = m_iss && !mv_done && (m_age == TIMEOUT);
            mv_bad      = 0;
            m_act       = m_iss && (m_age == 0);
            if (mv_done && (m_cur[3:0] == 4'd1)) begin
                m_res = bus.cop_data;
                m_rv  = 1;
            end else if (bus.result_ack === 1'b1) begin
                m_rv = 0;
            end
            if (mv_done || mv_tmo) m_iss = 0;
            else if (m_iss)        m_age++;
            if (mv_can_pop) begin
                mv_head = m_q.pop_front();
                if (mv_head[3:0] >= 4'd1 && mv_head[3:0] <= 4'd12) begin
                    m_iss = 1;
                    m_age = 0;
                    m_cur = mv_head;
                end else begin
                    mv_bad = 1;
                end
            end
            if (bus.host_valid === 1'b1 && mv_can_push) m_q.push_back(bus.host_instr);
            if (mv_bad)       m_eo = 1;
            else if (err_clr) m_eo = 0;
            if (mv_tmo)       m_et = 1;
            else if (err_clr) m_et = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(count), 32'(m_q.size()));
            check("host_ready", 32'(bus.host_ready), 32'(m_q.size() < DEPTH));
            check("busy", 32'(busy), 32'(m_iss || (m_q.size() != 0)));
            check("instruction", bus.instruction, m_cur);
            check("activate", 32'(bus.activate_instruction), 32'(m_act));
            check("result", 32'(bus.result), 32'(m_res));
            check("result_valid", 32'(bus.result_valid), 32'(m_rv));
            check("err_opcode", 32'(err_opcode), 32'(m_eo));
            check("err_timeout", 32'(err_timeout), 32'(m_et));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] w, output int e);
        bus.host_instr = w;
        bus.host_valid = 1'b1;
        @(negedge clk);
        bus.host_valid = 1'b0;
        e = cyc;
    endtask

    task automatic wait_activate(output int e);
        int n = 0;
        e = -1;
        while (bus.activate_instruction !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.activate_instruction !== 1'b1) begin
            n_fail++;
            $display("FAIL activate_wait: no issue pulse within 40 cycles (cycle %0d)", cyc);
        end else begin
            e = cyc;
        end
    endtask

    task automatic done_after(input logic [15:0] d, input int dly, output int e);
        repeat (dly) @(negedge clk);
        bus.cop_done = 1'b1;
        bus.cop_data = d;
        @(negedge clk);
        bus.cop_done = 1'b0;
        bus.cop_data = '0;
        e = cyc;
    endtask

    task automatic pulse_ack();
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    logic [3:0] ops [9] = '{4'd2, 4'd3, 4'd4, 4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12};

    // ---------------- directed scenarios ----------------
    initial begin : main
        int pe, ae, de, n;
        logic [31:0] words [9];

        bus.host_instr = '0;
        bus.host_valid = 1'b0;
        bus.cop_done   = 1'b0;
        bus.cop_data   = '0;
        bus.result_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset values
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(bus.host_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_instr", bus.instruction, 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);

        // Single READ, completion 5 cycles after issue
        push(32'h0000_0021, pe);
        wait_activate(ae);
        check("t1_issue_latency", 32'(ae - pe), 32'd2);
        check("t1_instr", bus.instruction, 32'h0000_0021);
        done_after(16'hBEEF, 4, de);
        check("t1_done_delay", 32'(de - ae), 32'd5);
        check("t1_result", 32'(bus.result), 32'h0000_BEEF);
        check("t1_result_valid", 32'(bus.result_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        pulse_ack();
        check("t1_ack", 32'(bus.result_valid), 32'd0);

        // Fill the queue behind one outstanding instruction
        for (int i = 0; i < 9; i++) words[i] = {16'hA5A5, 8'(i), 4'h0, ops[i]};
        for (int i = 0; i < 9; i++) push(words[i], pe);
        check("t2_full_count", 32'(count), 32'd8);
        check("t2_full_ready", 32'(bus.host_ready), 32'd0);
        push(32'h0000_0FF2, pe);
        check("t2_ignored_push", 32'(count), 32'd8);
        check("t2_instr0", bus.instruction, words[0]);
        done_after(16'h1000, 0, de);
        for (int k = 1; k < 9; k++) begin
            wait_activate(ae);
            check("t2_order", bus.instruction, words[k]);
            check("t2_spacing", 32'((ae - de) >= 2), 32'd1);
            done_after(16'(16'h1000 + k), 1, de);
        end
        check("t2_drained", 32'(count), 32'd0);
        check("t2_read_result", 32'(bus.result), 32'h0000_1003);

        // Illegal opcode dropped, following WRITE issued
        pulse_ack();
        push(32'h0000_00AF, pe);
        push(32'h0000_5672, pe);
        wait_activate(ae);
        check("t3_instr", bus.instruction, 32'h0000_5672);
        check("t3_err_opcode", 32'(err_opcode), 32'd1);
        done_after(16'h7777, 1, de);
        check("t3_no_result", 32'(bus.result_valid), 32'd0);
        pulse_clr();
        check("t3_err_clr", 32'(err_opcode), 32'd0);

        // SUM with no completion times out
        push(32'h0000_0123, pe);
        wait_activate(ae);
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_err_timeout", 32'(err_timeout), 32'd1);
        check("t4_timeout_delay", 32'(cyc - ae), 32'd16);
        check("t4_idle", 32'(fsm_state), 32'(ST_IDLE));
        pulse_clr();
        check("t4_err_clr", 32'(err_timeout), 32'd0);

        // Reset in WAIT with three queued entries
        push(32'h0000_0031, pe);
        wait_activate(ae);
        push(32'h0000_0102, pe);
        push(32'h0000_0203, pe);
        push(32'h0000_0304, pe);
        check("t5_queued", 32'(count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_count", 32'(count), 32'd0);
        check("t5_ready", 32'(bus.host_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_instr", bus.instruction, 32'd0);
        done_after(16'hDEAD, 0, de);
        @(negedge clk);
        check("t5_late_done_rv", 32'(bus.result_valid), 32'd0);
        check("t5_late_done_res", 32'(bus.result), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
